// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle RV32I subset: FSM states, ALU op classes,
// opcodes and every datapath mux/control constant.
package cpu_pkg;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXECUTER,
        S_EXECUTEI,
        S_ALUWB,
        S_JAL,
        S_BEQ
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2 = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU op class plus instruction fields onto an ALUControl code.
module alu_decoder
    import cpu_pkg::*;
(
    input  aluop_t     aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       op5_i,
    input  logic       funct7b5_i,
    output logic [2:0] alu_control_o
);

    always_comb begin
        alu_control_o = ALU_ADD;
        case (aluop_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3_i)
                    // funct7b5 only selects sub for register ops; addi ignores it
                    3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control_o = ALU_SLT;
                    3'b110:  alu_control_o = ALU_OR;
                    3'b111:  alu_control_o = ALU_AND;
                    default: alu_control_o = ALU_ADD;
                endcase
            end
            default: alu_control_o = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Moore main FSM for the multicycle core; drives every enable and mux select
// of the shared datapath, with ALUControl and ImmSrc decoded from the instruction.
module mc_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic       RegWrite,
    output logic       Illegal
);

    state_t state_q, state_d;
    aluop_t aluop;
    logic   pc_update, branch, mem_write, ir_write, reg_write, illegal;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = S_FETCH;
        aluop     = ALUOP_ADD;
        pc_update = 1'b0;
        branch    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RD2;
        case (state_q)
            S_FETCH: begin
                ir_write  = 1'b1;
                ALUSrcB   = SRCB_4;
                ResultSrc = RES_ALURESULT;
                pc_update = 1'b1;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                AdrSrc  = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RD1;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RD1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: reg_write = 1'b1;
            S_JAL: begin
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_4;
                pc_update = 1'b1;
                state_d   = S_ALUWB;
            end
            S_BEQ: begin
                ALUSrcA = SRCA_RD1;
                aluop   = ALUOP_SUB;
                branch  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every architectural write so an interrupted instruction is harmless
    assign PCWrite  = (pc_update | (branch & Zero)) & ~rst;
    assign IRWrite  = ir_write  & ~rst;
    assign RegWrite = reg_write & ~rst;
    assign MemWrite = mem_write & ~rst;
    assign Illegal  = illegal   & ~rst;

    always_comb begin
        case (op)
            OP_SW:   ImmSrc = IMM_S;
            OP_BEQ:  ImmSrc = IMM_B;
            OP_JAL:  ImmSrc = IMM_J;
            default: ImmSrc = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .aluop_i      (aluop),
        .funct3_i     (funct3),
        .op5_i        (op[5]),
        .funct7b5_i   (funct7b5),
        .alu_control_o(ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed cycle-by-cycle check of the multicycle controller outputs for each
// instruction class, illegal opcodes and reset mid-instruction.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, Illegal;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;

    int vectors = 0;
    int errors  = 0;

    mc_controller dut (
        .clk       (clk),
        .rst       (rst),
        .op        (op),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .Zero      (Zero),
        .PCWrite   (PCWrite),
        .AdrSrc    (AdrSrc),
        .MemWrite  (MemWrite),
        .IRWrite   (IRWrite),
        .ResultSrc (ResultSrc),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUControl(ALUControl),
        .ImmSrc    (ImmSrc),
        .RegWrite  (RegWrite),
        .Illegal   (Illegal)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Field order: pcw adr mw ir rs srca srcb aluctl imm rw ill
    task automatic chk(input string tag, input logic pcw, input logic adr, input logic mw,
                       input logic ir, input logic [1:0] rs, input logic [1:0] a,
                       input logic [1:0] b, input logic [2:0] alu, input logic [1:0] imm,
                       input logic rw, input logic ill);
        logic [16:0] obs, expv;
        obs  = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                ALUControl, ImmSrc, RegWrite, Illegal};
        expv = {pcw, adr, mw, ir, rs, a, b, alu, imm, rw, ill};
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        op = o; funct3 = f3; funct7b5 = f7;
        #1;
    endtask

    initial begin
        rst = 1'b1; Zero = 1'b0;
        // lw x6, -4(x9) = 0xFFC4A303: funct3=010, bit30=1
        op = 7'b0000011; funct3 = 3'b010; funct7b5 = 1'b1;
        tick(); tick();
        chk("reset_hold", 0,0,0,0, 2'b10,2'b00,2'b10,3'b000,2'b00, 0,0);
        rst = 1'b0; #1;
        chk("lw_fetch",   1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b00, 0,0);
        tick(); chk("lw_decode",  0,0,0,0, 2'b00,2'b01,2'b01,3'b000,2'b00, 0,0);
        tick(); chk("lw_memadr",  0,0,0,0, 2'b00,2'b10,2'b01,3'b000,2'b00, 0,0);
        tick(); chk("lw_memread", 0,1,0,0, 2'b00,2'b00,2'b00,3'b000,2'b00, 0,0);
        tick(); chk("lw_memwb",   0,0,0,0, 2'b01,2'b00,2'b00,3'b000,2'b00, 1,0);

        // R-type sub
        tick(); set_instr(7'b0110011, 3'b000, 1'b1);
        chk("sub_fetch",   1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b00, 0,0);
        tick(); chk("sub_decode", 0,0,0,0, 2'b00,2'b01,2'b01,3'b000,2'b00, 0,0);
        tick(); chk("sub_execr",  0,0,0,0, 2'b00,2'b10,2'b00,3'b001,2'b00, 0,0);
        tick(); chk("sub_aluwb",  0,0,0,0, 2'b00,2'b00,2'b00,3'b000,2'b00, 1,0);

        // R-type and
        tick(); set_instr(7'b0110011, 3'b111, 1'b0);
        chk("and_fetch",   1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b00, 0,0);
        tick(); tick();
        chk("and_execr",  0,0,0,0, 2'b00,2'b10,2'b00,3'b010,2'b00, 0,0);
        tick(); chk("and_aluwb",  0,0,0,0, 2'b00,2'b00,2'b00,3'b000,2'b00, 1,0);

        // addi with bit30 set must still add; then ori
        tick(); set_instr(7'b0010011, 3'b000, 1'b1);
        tick(); tick();
        chk("addi_execi", 0,0,0,0, 2'b00,2'b10,2'b01,3'b000,2'b00, 0,0);
        tick(); chk("addi_aluwb", 0,0,0,0, 2'b00,2'b00,2'b00,3'b000,2'b00, 1,0);
        tick(); set_instr(7'b0010011, 3'b110, 1'b0);
        tick(); tick();
        chk("ori_execi",  0,0,0,0, 2'b00,2'b10,2'b01,3'b011,2'b00, 0,0);
        tick();
        tick(); set_instr(7'b0110011, 3'b010, 1'b0);
        tick(); tick();
        chk("slt_execr",  0,0,0,0, 2'b00,2'b10,2'b00,3'b101,2'b00, 0,0);
        tick();

        // beq taken: Zero high throughout must not leak into Decode
        tick(); set_instr(7'b1100011, 3'b000, 1'b0); Zero = 1'b1; #1;
        chk("beqT_fetch",  1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b10, 0,0);
        tick(); chk("beqT_decode", 0,0,0,0, 2'b00,2'b01,2'b01,3'b000,2'b10, 0,0);
        tick(); chk("beqT_beq",    1,0,0,0, 2'b00,2'b10,2'b00,3'b001,2'b10, 0,0);
        Zero = 1'b0; #1;
        chk("beq_zero_comb", 0,0,0,0, 2'b00,2'b10,2'b00,3'b001,2'b10, 0,0);

        // beq not taken
        tick(); chk("beqN_fetch",  1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b10, 0,0);
        tick(); tick();
        chk("beqN_beq",    0,0,0,0, 2'b00,2'b10,2'b00,3'b001,2'b10, 0,0);

        // sw
        tick(); set_instr(7'b0100011, 3'b010, 1'b0);
        chk("sw_fetch",    1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b01, 0,0);
        tick(); chk("sw_decode",   0,0,0,0, 2'b00,2'b01,2'b01,3'b000,2'b01, 0,0);
        tick(); chk("sw_memadr",   0,0,0,0, 2'b00,2'b10,2'b01,3'b000,2'b01, 0,0);
        tick(); chk("sw_memwrite", 0,1,1,0, 2'b00,2'b00,2'b00,3'b000,2'b01, 0,0);

        // jal
        tick(); set_instr(7'b1101111, 3'b000, 1'b0);
        chk("jal_fetch",   1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b11, 0,0);
        tick(); tick();
        chk("jal_jal",     1,0,0,0, 2'b00,2'b01,2'b10,3'b000,2'b11, 0,0);
        tick(); chk("jal_aluwb",   0,0,0,0, 2'b00,2'b00,2'b00,3'b000,2'b11, 1,0);

        // illegal opcode
        tick(); set_instr(7'b1111111, 3'b000, 1'b0);
        chk("ill_fetch",   1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b00, 0,0);
        tick(); chk("ill_decode",  0,0,0,0, 2'b00,2'b01,2'b01,3'b000,2'b00, 0,1);
        tick(); chk("ill_refetch", 1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b00, 0,0);

        // reset asserted during MemWrite
        set_instr(7'b0100011, 3'b010, 1'b0);
        tick(); tick(); tick();
        chk("rstmw_pre",   0,1,1,0, 2'b00,2'b00,2'b00,3'b000,2'b01, 0,0);
        rst = 1'b1; #1;
        chk("rstmw_mask",  0,1,0,0, 2'b00,2'b00,2'b00,3'b000,2'b01, 0,0);
        tick(); chk("rstmw_fetch", 0,0,0,0, 2'b10,2'b00,2'b10,3'b000,2'b01, 0,0);
        rst = 1'b0; #1;
        chk("rstmw_resume", 1,0,0,1, 2'b10,2'b00,2'b10,3'b000,2'b01, 0,0);
        tick(); chk("rstmw_decode", 0,0,0,0, 2'b00,2'b01,2'b01,3'b000,2'b01, 0,0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
# mc_controller

Multicycle control unit for the RV32I core subset lw, sw, R-type, I-type ALU, beq and jal. It sequences the shared datapath (pc, register_bank, Extend, ALU, unified memory) through a Moore main FSM plus combinational ALU and immediate decoders. Each instruction is spread over 3–5 cycles so one ALU and one memory port serve fetch, address generation and execute. The block sits beside the datapath and drives every enable and mux select in it.

## Interface
- No parameters; all encodings come from `cpu_pkg`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `op` in 7: Instr[6:0].
- `funct3` in 3: Instr[14:12].
- `funct7b5` in 1: Instr[30].
- `Zero` in 1: ALU result == 0.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 = PC, 1 = ALUOut.
- `MemWrite` out 1: memory write enable.
- `IRWrite` out 1: instruction register and OldPC enable.
- `ResultSrc` out 2: result select. 00 = ALUOut, 01 = Data, 10 = ALUResult.
- `ALUSrcA` out 2: ALU A select. 00 = PC, 01 = OldPC, 10 = RD1 reg.
- `ALUSrcB` out 2: ALU B select. 00 = RD2 reg, 01 = ImmExt, 10 = 4.
- `ALUControl` out 3: ALU operation. 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmSrc` out 2: immediate format. 00 I, 01 S, 10 B, 11 J.
- `RegWrite` out 1: register file write enable.
- `Illegal` out 1: one-cycle pulse on an unsupported opcode.

## Operation
- Outputs depend on the state only. The exceptions are `PCWrite` (Zero-gated), and `ImmSrc` and `ALUControl` (decoded from the instruction fields).
- Unlisted outputs are 0 in every state.
- `PCWrite = PCUpdate | (Branch & Zero)`.

FSM states, their outputs, and next state:
- **Fetch**: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ALUOp=add, ResultSrc=10, PCUpdate=1. Next: Decode.
- **Decode**: ALUSrcA=01, ALUSrcB=01, ALUOp=add (precomputes the branch target). Next by op:
  - 0000011 or 0100011 → MemAdr
  - 0110011 → ExecuteR
  - 0010011 → ExecuteI
  - 1100011 → BEQ
  - 1101111 → JAL
  - any other op → Fetch, with Illegal=1 for this cycle
- **MemAdr**: ALUSrcA=10, ALUSrcB=01, ALUOp=add. Next: MemRead if op=0000011, else MemWrite.
- **MemRead**: AdrSrc=1, ResultSrc=00. Next: MemWB.
- **MemWB**: ResultSrc=01, RegWrite=1. Next: Fetch.
- **MemWrite**: AdrSrc=1, MemWrite=1. Next: Fetch.
- **ExecuteR**: ALUSrcA=10, ALUSrcB=00, ALUOp=funct. Next: ALUWB.
- **ExecuteI**: ALUSrcA=10, ALUSrcB=01, ALUOp=funct. Next: ALUWB.
- **ALUWB**: ResultSrc=00, RegWrite=1. Next: Fetch.
- **JAL**: ALUSrcA=01, ALUSrcB=10, ALUOp=add, ResultSrc=00, PCUpdate=1. Next: ALUWB.
- **BEQ**: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, Branch=1. Next: Fetch.

ALU decoder:
- ALUOp add → 000; ALUOp sub → 001.
- ALUOp funct, by funct3:
  - 000: sub (001) when op[5] & funct7b5, else add (000).
  - 010: slt (101).
  - 110: or (011).
  - 111: and (010).
  - other: 000.

ImmSrc decode by op:
- 0100011 → 01
- 1100011 → 10
- 1101111 → 11
- everything else → 00

## Timing
- Reset: `rst` sampled at posedge; the next state is Fetch.
- While `rst`=1, PCWrite, IRWrite, RegWrite, MemWrite and Illegal are forced to 0. This overrides the state, so reset mid-instruction never writes.
- First Fetch is the cycle after `rst` falls.
- Cycles per instruction, Fetch to Fetch exclusive:
  - lw 5
  - sw 4
  - R 4
  - I 4
  - jal 4
  - beq 3
  - illegal 2
- `Zero` is only meaningful in BEQ. PCWrite follows it combinationally in that same cycle.
- No stalls, no handshake: memory is assumed single-cycle.

## Structure
- `cpu_pkg` holds:
  - `state_t` enum with the 11 states
  - `aluop_t` (add, sub, funct)
  - opcode localparams
  - ALUControl, ImmSrc, ResultSrc and ALUSrc localparams; the ALU shares the ALUControl constants
- Sub-module `alu_decoder`, combinational: inputs ALUOp, funct3, op[5], funct7b5; output ALUControl.
- `mc_controller` contains the state register, next-state logic, output decode and the ImmSrc decode.

## Test plan
- **lw**: op=0000011 (instruction 0xFFC4A303), with rst released → states Fetch, Decode, MemAdr, MemRead, MemWB, Fetch. ImmSrc=00 throughout; RegWrite=1 only in cycle 5; ResultSrc=01 in cycle 5.
- **R-type sub then and**:
  - op=0110011, funct3=000, funct7b5=1 → ALUControl=001 in ExecuteR, RegWrite=1 in ALUWB.
  - op=0110011, funct3=111 → ALUControl=010.
- **beq**: op=1100011 with Zero=1 in BEQ → PCWrite=1 in cycles 1 and 3. With Zero=0 → PCWrite=1 in cycle 1 only. ImmSrc=10 in both cases.
- **sw**: op=0100011 → MemWrite=1 only in cycle 4 with AdrSrc=1, and RegWrite=0 throughout.
- **Illegal opcode**: op=1111111 → Illegal=1 in Decode only, Fetch on the next cycle, no RegWrite or MemWrite.
- **Reset during MemWrite**: rst=1 → MemWrite=0 in that cycle; state is Fetch after the edge; normal fetch resumes once rst=0.
